imem_fetch_ctrl: RTL and testbench
==================================

Name: imem_fetch_ctrl

Overview:
- Instruction-fetch sequencer placed in front of the combinational instruction_memory ROM; owns the program counter and drives the ROM address.
- Captures the returned word into a single-entry instruction register (IR) and hands it to decode through a valid/ready handshake.
- Applies branch/jump/jal/jr redirects from execute, stops cleanly on halt, and traps misaligned targets.

Parameters:
- RESET_PC, 32'd0, PC loaded on reset; must be word-aligned.
- PC_STEP, 32'd4, sequential increment in bytes.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- imem_addr  output  32  ROM address; combinational copy of the PC register.
- imem_instr  input  32  ROM data for imem_addr, valid in the same cycle.
- out_valid  output  1  IR holds an instruction for decode.
- out_ready  input  1  decode accepts the IR this cycle.
- out_instr  output  32  IR instruction word.
- out_pc  output  32  address out_instr was fetched from.
- out_pc_plus4  output  32  out_pc + PC_STEP, used as the jal link value.
- redirect_valid  input  1  execute requests a PC change (taken beq, j, jal, jr).
- redirect_target  input  32  new PC.
- halt  input  1  stop fetching; sampled while RUN.
- halted  output  1  HALT state reached and IR drained.
- fault  output  1  sticky misaligned-redirect trap.
- fetch_count  output  32  instructions accepted by decode; saturates at 32'hFFFFFFFF.

Behaviour:
- Reset (rst_n low, asynchronous, any state or mid-handshake):
  - pc = RESET_PC; out_valid = 0; out_instr = 0; out_pc = 0; fault = 0; halted = 0; fetch_count = 0; state = RUN.
  - out_pc_plus4 is combinational from out_pc, so it reads PC_STEP during reset.
- States:
  - RUN: normal fetch.
  - HALT: no new fetches; the IR may still drain.
  - FAULT: terminal.
  - Only rst_n leaves HALT or FAULT.
- Fetch enable: fe = (state == RUN) && (!out_valid || out_ready) && !redirect_valid && !halt.
  - When fe is high, on the clock edge: out_instr <= imem_instr, out_pc <= pc, out_valid <= 1, pc <= pc + PC_STEP.
  - The PC wraps modulo 2^32 (32'hFFFFFFFC + 4 = 0).
- Latency:
  - First out_valid rises on the first rising edge after rst_n deasserts.
  - Sustained throughput is one instruction per cycle while out_ready stays high.
- Stall: out_valid && !out_ready holds out_instr, out_pc and pc unchanged. Back-pressure loses no instructions.
- Accept: out_valid && out_ready increments fetch_count, including in the same cycle as a redirect or halt.
- Redirect (state RUN, redirect_valid = 1):
  - Highest priority in RUN.
  - If redirect_target[1:0] != 0: state <= FAULT, fault <= 1, out_valid <= 0, pc unchanged.
  - Otherwise: pc <= redirect_target and out_valid <= 0 (the IR is flushed whether or not it was accepted). The target instruction appears in the IR one edge later, giving exactly one bubble cycle.
  - Redirect and halt in the same cycle: the redirect is applied to pc, then state <= HALT.
  - Redirect while in HALT or FAULT is ignored.
- Halt (state RUN, halt = 1):
  - state <= HALT; pc frozen.
  - A valid IR stays valid until accepted; no new fetch occurs.
  - halted = 1 in every cycle where state == HALT and out_valid == 0; this output is registered.
- FAULT: out_valid = 0; imem_addr holds the last good pc; fault and state hold until reset.
- fetch_count saturates and never wraps.

Test Plan:
- Reset release with the standard program loaded (addr 0 = 32'h20100000) and out_ready = 1:
  - 1st edge: out_valid = 1, out_instr = 32'h20100000, out_pc = 0, imem_addr = 4.
  - After 4 edges: out_pc = 12, fetch_count = 3.
- Back-pressure: at out_pc = 8, hold out_ready = 0 for 3 cycles:
  - out_instr stays 32'hAE040000 and imem_addr stays 12.
  - After release, next out_pc = 12; no skip or duplicate.
- Redirect: when out_pc = 36 (instr 32'h0C00000D), pulse redirect_valid with target 52:
  - Next cycle out_valid = 0.
  - Following cycle out_pc = 52 and out_pc_plus4 = 40 + 16 = 56; link for the jal was out_pc_plus4 = 40.
- Misaligned redirect target 32'd50:
  - fault = 1 and out_valid = 0 after the edge.
  - Stays faulted with no fetch for 10 cycles; rst_n low clears it.
- Halt while out_valid = 1 and out_ready = 0:
  - halted = 0 until out_ready pulses; halted = 1 the cycle after the accept.
  - pc is frozen throughout; a later redirect_valid pulse has no effect.
- Asynchronous reset asserted mid-stall at out_pc = 20:
  - All outputs return to reset values immediately, without waiting for a clock edge.
  - Refetch restarts at 0.

Source files
------------

// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, drives the ROM address and presents
// the fetched word to decode through a single-entry valid/ready instruction register.
module imem_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'd0,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic [31:0] out_pc_plus4,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic        halt,
    output logic        halted,
    output logic        fault,
    output logic [31:0] fetch_count
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HALT  = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    state_t      state_r, state_nxt_s;
    logic [31:0] pc_r, pc_nxt_s;
    logic        valid_r, valid_nxt_s;
    logic [31:0] instr_r, instr_nxt_s;
    logic [31:0] opc_r, opc_nxt_s;
    logic        fault_r, fault_nxt_s;
    logic        halted_r, halted_nxt_s;
    logic [31:0] cnt_r, cnt_nxt_s;
    logic        accept_s;
    logic        fe_s;

    assign accept_s = valid_r && out_ready;
    assign fe_s     = (state_r == ST_RUN) && (!valid_r || out_ready) && !redirect_valid && !halt;

    // Next-state and next-output computation for the fetch sequencer
    always_comb begin
        state_nxt_s = state_r;
        pc_nxt_s    = pc_r;
        valid_nxt_s = valid_r;
        instr_nxt_s = instr_r;
        opc_nxt_s   = opc_r;
        fault_nxt_s = fault_r;
        case (state_r)
            ST_RUN: begin
                if (redirect_valid) begin
                    valid_nxt_s = 1'b0;
                    if (redirect_target[1:0] != 2'b00) begin
                        state_nxt_s = ST_FAULT;
                        fault_nxt_s = 1'b1;
                    end else begin
                        pc_nxt_s    = redirect_target;
                        state_nxt_s = halt ? ST_HALT : ST_RUN;
                    end
                end else if (halt) begin
                    state_nxt_s = ST_HALT;
                    valid_nxt_s = accept_s ? 1'b0 : valid_r;
                end else if (fe_s) begin
                    instr_nxt_s = imem_instr;
                    opc_nxt_s   = pc_r;
                    valid_nxt_s = 1'b1;
                    pc_nxt_s    = pc_r + PC_STEP;
                end else begin
                    valid_nxt_s = valid_r;
                end
            end
            ST_HALT: begin
                valid_nxt_s = accept_s ? 1'b0 : valid_r;
            end
            ST_FAULT: begin
                valid_nxt_s = 1'b0;
            end
            default: begin
                // An illegal encoding is treated as a trap rather than silently resumed
                state_nxt_s = ST_FAULT;
                fault_nxt_s = 1'b1;
                valid_nxt_s = 1'b0;
            end
        endcase
        if (accept_s && (cnt_r != 32'hFFFF_FFFF)) begin
            cnt_nxt_s = cnt_r + 32'd1;
        end else begin
            cnt_nxt_s = cnt_r;
        end
        halted_nxt_s = (state_nxt_s == ST_HALT) && !valid_nxt_s;
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_RUN;
            pc_r     <= RESET_PC;
            valid_r  <= 1'b0;
            instr_r  <= 32'd0;
            opc_r    <= 32'd0;
            fault_r  <= 1'b0;
            halted_r <= 1'b0;
            cnt_r    <= 32'd0;
        end else begin
            state_r  <= state_nxt_s;
            pc_r     <= pc_nxt_s;
            valid_r  <= valid_nxt_s;
            instr_r  <= instr_nxt_s;
            opc_r    <= opc_nxt_s;
            fault_r  <= fault_nxt_s;
            halted_r <= halted_nxt_s;
            cnt_r    <= cnt_nxt_s;
        end
    end

    assign imem_addr    = pc_r;
    assign out_valid    = valid_r;
    assign out_instr    = instr_r;
    assign out_pc       = opc_r;
    assign out_pc_plus4 = opc_r + PC_STEP;
    assign halted       = halted_r;
    assign fault        = fault_r;
    assign fetch_count  = cnt_r;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl: reset, streaming, back-pressure, redirect,
// misaligned trap, halt drain and asynchronous reset mid-stall.
module tb_imem_fetch_ctrl;

    logic        clk;
    logic        rst_n;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_pc_plus4;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        halt;
    logic        halted;
    logic        fault;
    logic [31:0] fetch_count;

    int n_cmp;
    int n_err;

    imem_fetch_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_pc_plus4   (out_pc_plus4),
        .redirect_valid (redirect_valid),
        .redirect_target(redirect_target),
        .halt           (halt),
        .halted         (halted),
        .fault          (fault),
        .fetch_count    (fetch_count)
    );

    // Standard program: a few known words, everything else tagged with its address
    function automatic logic [31:0] rom(input logic [31:0] addr);
        case (addr)
            32'd0:   rom = 32'h2010_0000;
            32'd8:   rom = 32'hAE04_0000;
            32'd36:  rom = 32'h0C00_000D;
            default: rom = {16'hC0DE, addr[15:0]};
        endcase
    endfunction

    assign imem_instr = rom(imem_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, ".instr"}, out_instr, 32'd0);
        chk({tag, ".pc"}, out_pc, 32'd0);
        chk({tag, ".pc4"}, out_pc_plus4, 32'd4);
        chk({tag, ".addr"}, imem_addr, 32'd0);
        chk({tag, ".fault"}, {31'd0, fault}, 32'd0);
        chk({tag, ".halted"}, {31'd0, halted}, 32'd0);
        chk({tag, ".cnt"}, fetch_count, 32'd0);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        out_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_target = 32'd0;
        halt = 1'b0;
        #2;
        chk_reset_vals("rst");
        step();
        rst_n = 1'b1;

        // Streaming from reset
        step();
        chk("e1.valid", {31'd0, out_valid}, 32'd1);
        chk("e1.instr", out_instr, 32'h2010_0000);
        chk("e1.pc", out_pc, 32'd0);
        chk("e1.addr", imem_addr, 32'd4);
        chk("e1.cnt", fetch_count, 32'd0);
        step();
        step();
        chk("e3.pc", out_pc, 32'd8);
        chk("e3.instr", out_instr, 32'hAE04_0000);
        chk("e3.addr", imem_addr, 32'd12);
        chk("e3.cnt", fetch_count, 32'd2);

        // Back-pressure at out_pc = 8
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp.instr", out_instr, 32'hAE04_0000);
            chk("bp.addr", imem_addr, 32'd12);
            chk("bp.cnt", fetch_count, 32'd2);
        end
        out_ready = 1'b1;
        step();
        chk("bp.rel.pc", out_pc, 32'd12);
        chk("bp.rel.cnt", fetch_count, 32'd3);
        chk("bp.rel.addr", imem_addr, 32'd16);

        // Run up to the jal at 36
        for (int i = 0; i < 6; i++) step();
        chk("jal.pc", out_pc, 32'd36);
        chk("jal.instr", out_instr, 32'h0C00_000D);
        chk("jal.link", out_pc_plus4, 32'd40);
        chk("jal.cnt", fetch_count, 32'd9);
        redirect_valid = 1'b1;
        redirect_target = 32'd52;
        step();
        redirect_valid = 1'b0;
        chk("rd.bubble", {31'd0, out_valid}, 32'd0);
        chk("rd.addr", imem_addr, 32'd52);
        chk("rd.cnt", fetch_count, 32'd10);
        step();
        chk("rd.valid", {31'd0, out_valid}, 32'd1);
        chk("rd.pc", out_pc, 32'd52);
        chk("rd.pc4", out_pc_plus4, 32'd56);
        chk("rd.instr", out_instr, 32'hC0DE_0034);

        // Misaligned target traps
        redirect_valid = 1'b1;
        redirect_target = 32'd50;
        step();
        redirect_valid = 1'b0;
        chk("mis.fault", {31'd0, fault}, 32'd1);
        chk("mis.valid", {31'd0, out_valid}, 32'd0);
        chk("mis.addr", imem_addr, 32'd56);
        chk("mis.cnt", fetch_count, 32'd11);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("mis.hold.fault", {31'd0, fault}, 32'd1);
            chk("mis.hold.valid", {31'd0, out_valid}, 32'd0);
            chk("mis.hold.addr", imem_addr, 32'd56);
        end
        rst_n = 1'b0;
        #1;
        chk_reset_vals("mis.rst");

        // Halt while the IR is stalled
        step();
        rst_n = 1'b1;
        out_ready = 1'b0;
        step();
        chk("h.valid", {31'd0, out_valid}, 32'd1);
        chk("h.addr", imem_addr, 32'd4);
        halt = 1'b1;
        step();
        halt = 1'b0;
        chk("h.valid1", {31'd0, out_valid}, 32'd1);
        chk("h.halted1", {31'd0, halted}, 32'd0);
        chk("h.addr1", imem_addr, 32'd4);
        for (int i = 0; i < 2; i++) begin
            step();
            chk("h.wait.halted", {31'd0, halted}, 32'd0);
            chk("h.wait.addr", imem_addr, 32'd4);
        end
        out_ready = 1'b1;
        step();
        chk("h.acc.valid", {31'd0, out_valid}, 32'd0);
        chk("h.acc.halted", {31'd0, halted}, 32'd1);
        chk("h.acc.cnt", fetch_count, 32'd1);
        redirect_valid = 1'b1;
        redirect_target = 32'd64;
        step();
        redirect_valid = 1'b0;
        chk("h.rd.addr", imem_addr, 32'd4);
        chk("h.rd.halted", {31'd0, halted}, 32'd1);
        chk("h.rd.valid", {31'd0, out_valid}, 32'd0);

        // Asynchronous reset mid-stall at out_pc = 20
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) step();
        chk("ar.pc", out_pc, 32'd20);
        out_ready = 1'b0;
        step();
        step();
        chk("ar.stall.pc", out_pc, 32'd20);
        chk("ar.stall.cnt", fetch_count, 32'd5);
        #3;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("ar");
        step();
        rst_n = 1'b1;
        out_ready = 1'b1;
        step();
        chk("ar.re.pc", out_pc, 32'd0);
        chk("ar.re.instr", out_instr, 32'h2010_0000);
        chk("ar.re.addr", imem_addr, 32'd4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
